load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Sits between the execute stage and data memory. Turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory beats with byte enables.
// - Splits any access that crosses a 32-bit word boundary into two beats, stalling the core while it does so.
// - Extracts, sign-extends or zero-extends load data.
// PARAMETERS
// - DATA_WIDTH  32  data and core address width
// - ADDR_WIDTH  17  data memory byte-address width (0x00000-0x1FFFF); beat addresses wrap modulo 2^ADDR_WIDTH
// PORTS
// - clk        in   1           clock, rising edge
// - rst        in   1           reset, asynchronous, active-high
// - req_valid  in   1           core presents a load/store this cycle
// - req_we     in   1           1 = store, 0 = load
// - funct3     in   3           RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - addr       in   DATA_WIDTH  byte address (ALU result)
// - wdata      in   DATA_WIDTH  store data, right-justified
// - stall      out  1           core must hold its request and pipeline this cycle
// - rsp_valid  out  1           rdata valid this cycle (loads only)
// - rdata      out  DATA_WIDTH  extended load result
// - err        out  1           one-cycle pulse: illegal funct3 (011/110/111); no memory access is made
// - mem_en     out  1           beat valid
// - mem_we     out  1           beat is a write
// - mem_addr   out  ADDR_WIDTH  beat address, bits[1:0] = 0
// - mem_be     out  4           byte enables, little-endian lanes
// - mem_wdata  out  DATA_WIDTH  lane-aligned write data
// - mem_rdata  in   DATA_WIDTH  read data, valid the cycle after a read beat
// BEHAVIOUR
// - off = addr[1:0]; size mask m = 0001 (B), 0011 (H), 1111 (W).
// - be8 = m << off; beats needed = 2 when be8[7:4] != 0, otherwise 1.
// - Writes: wd64 = {32'b0, wdata} << 8*off. Beat 0 gets be8[3:0] and wd64[31:0]; beat 1 gets be8[7:4] and wd64[63:32].
// - Beat 0 address = addr[ADDR_WIDTH-1:2]<<2. Beat 1 address = beat 0 address + 4, wrapping at 2^ADDR_WIDTH.
// - States: IDLE, LD_WAIT, LD_HI, LD_DONE, ST_HI.
// - In IDLE, beat 0 is issued combinationally in the request cycle (cycle 0). Requests arriving while not in IDLE are ignored; the core is stalled.
// - Single-beat store: write in cycle 0. stall = 0. State stays IDLE.
// - Two-beat store: beat 0 in cycle 0 with stall = 1, then go to ST_HI. Beat 1 in cycle 1 with stall = 0, then go to IDLE.
// - Single-beat load: read in cycle 0 with stall = 1, then go to LD_WAIT. In cycle 1: rsp_valid = 1, stall = 0, go to IDLE.
// - Two-beat load:
//   - Cycle 0: read beat 0, stall = 1, go to LD_HI.
//   - Cycle 1: latch mem_rdata as lo, read beat 1, stall = 1, go to LD_DONE.
//   - Cycle 2: rsp_valid = 1, stall = 0, go to IDLE.
// - Load result: r64 = {hi, lo} >> 8*off (for single-beat loads, hi = 0 and lo = mem_rdata).
//   - B/BU: take r64[7:0], sign-extend / zero-extend.
//   - H/HU: take r64[15:0], sign-extend / zero-extend.
//   - W: take r64[31:0].
// - Offset, size, sign flag and beat-1 address are registered at cycle 0. Later cycles never re-read addr, funct3 or wdata.
// - Illegal funct3 with req_valid: err = 1, mem_en = 0, stall = 0, state stays IDLE.
// - When not issuing a beat: mem_en, mem_we, mem_be, mem_wdata = 0. rdata = 0 whenever rsp_valid = 0.
// - Reset (asynchronous, any state): state goes to IDLE and all registers clear. While rst = 1, every output is forced to 0.
// - Reset mid-operation: any pending beat 1 is dropped. A half-written two-beat store leaves only beat 0 in memory. No rsp_valid is produced for the aborted load.
// TESTING
// - SW 0x11223344 at 0x100, then LW 0x100: one write beat (be 1111); load stalls 1 cycle; rdata = 0x11223344 in cycle 1.
// - SB 0xA5 at 0x103: be 1000, mem_wdata 0xA5000000. LB 0x103 returns 0xFFFFFFA5; LBU 0x103 returns 0x000000A5.
// - SW 0x11223344 at 0x0FE:
//   - Beat 0: 0x0FC, be 1100, data 0x33440000.
//   - Beat 1: 0x100, be 0011, data 0x00001122.
//   - stall high in cycle 0 only.
// - LW at 0x0FE after the store above: reads 0x0FC then 0x100; stall high in cycles 0-1; rsp_valid in cycle 2 with 0x11223344.
// - LH at 0x1FFFF: beat 0 at 0x1FFFC, beat 1 at 0x00000 (wrap). With bytes 0x80 and 0x01, rdata = 0x00000180.
// - rst pulsed in LD_HI: all outputs 0, no rsp_valid, IDLE next cycle. funct3 = 011 with req_valid: err pulses and mem_en stays 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I loads and stores into word-aligned memory
// beats with byte enables, splits word-crossing accesses into two beats
// and extends load data.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LD_WAIT, LD_HI, LD_DONE, ST_HI} state_t;

  state_t state_q, state_d;

  // Request context captured in the issue cycle
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr1_q;
  logic [3:0]            be_hi_q;
  logic [DATA_WIDTH-1:0] wd_hi_q;
  logic [DATA_WIDTH-1:0] lo_q;

  // Decode of the live request
  logic                    illegal;
  logic [3:0]              size_mask;
  logic [7:0]              be8;
  logic [2*DATA_WIDTH-1:0] wd64;
  logic [ADDR_WIDTH-1:0]   base;
  logic                    two_beats;
  logic                    capture;

  // Load data path
  logic [DATA_WIDTH-1:0] hi_word, lo_word, rword, rext;

  // Internal (pre-reset-gating) outputs
  logic                  stall_c, rsp_c, err_c, en_c, we_c;
  logic [DATA_WIDTH-1:0] rdata_c, wd_c;
  logic [ADDR_WIDTH-1:0] ma_c;
  logic [3:0]            be_c;

  logic addr_unused;
  assign addr_unused = ^addr[DATA_WIDTH-1:ADDR_WIDTH];

  // Decode size, lane enables, shifted store data and beat addresses
  always_comb begin
    illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    be8       = {4'b0000, size_mask} << addr[1:0];
    wd64      = {{DATA_WIDTH{1'b0}}, wdata} << {addr[1:0], 3'b000};
    base      = {addr[ADDR_WIDTH-1:2], 2'b00};
    two_beats = |be8[7:4];
  end

  // Align and extend load data; single-beat loads use hi = 0
  always_comb begin
    hi_word = (state_q == LD_DONE) ? mem_rdata : '0;
    lo_word = (state_q == LD_DONE) ? lo_q : mem_rdata;
    rword   = DATA_WIDTH'({hi_word, lo_word} >> {off_q, 3'b000});
    case (size_q)
      2'b00:   rext = uns_q ? {{(DATA_WIDTH-8){1'b0}}, rword[7:0]}
                            : {{(DATA_WIDTH-8){rword[7]}}, rword[7:0]};
      2'b01:   rext = uns_q ? {{(DATA_WIDTH-16){1'b0}}, rword[15:0]}
                            : {{(DATA_WIDTH-16){rword[15]}}, rword[15:0]};
      default: rext = rword;
    endcase
  end

  // Next-state and beat/response outputs
  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    rsp_c   = 1'b0;
    rdata_c = '0;
    err_c   = 1'b0;
    en_c    = 1'b0;
    we_c    = 1'b0;
    ma_c    = '0;
    be_c    = '0;
    wd_c    = '0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            err_c = 1'b1;
          end else begin
            capture = 1'b1;
            en_c    = 1'b1;
            we_c    = req_we;
            ma_c    = base;
            be_c    = be8[3:0];
            if (req_we) begin
              wd_c    = wd64[DATA_WIDTH-1:0];
              stall_c = two_beats;
              state_d = two_beats ? ST_HI : IDLE;
            end else begin
              stall_c = 1'b1;
              state_d = two_beats ? LD_HI : LD_WAIT;
            end
          end
        end
      end
      LD_WAIT: begin
        rsp_c   = 1'b1;
        rdata_c = rext;
        state_d = IDLE;
      end
      LD_HI: begin
        en_c    = 1'b1;
        ma_c    = addr1_q;
        be_c    = be_hi_q;
        stall_c = 1'b1;
        state_d = LD_DONE;
      end
      LD_DONE: begin
        rsp_c   = 1'b1;
        rdata_c = rext;
        state_d = IDLE;
      end
      ST_HI: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        ma_c    = addr1_q;
        be_c    = be_hi_q;
        wd_c    = wd_hi_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture request context at issue and the low word of split loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr1_q <= '0;
      be_hi_q <= '0;
      wd_hi_q <= '0;
      lo_q    <= '0;
    end else begin
      if (capture) begin
        off_q   <= addr[1:0];
        size_q  <= funct3[1:0];
        uns_q   <= funct3[2];
        addr1_q <= base + ADDR_WIDTH'(4);
        be_hi_q <= be8[7:4];
        wd_hi_q <= wd64[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      if (state_q == LD_HI) lo_q <= mem_rdata;
    end
  end

  // Every output held at zero while reset is asserted
  assign stall     = stall_c & ~rst;
  assign rsp_valid = rsp_c & ~rst;
  assign rdata     = rst ? '0 : rdata_c;
  assign err       = err_c & ~rst;
  assign mem_en    = en_c & ~rst;
  assign mem_we    = we_c & ~rst;
  assign mem_addr  = rst ? '0 : ma_c;
  assign mem_be    = rst ? '0 : be_c;
  assign mem_wdata = rst ? '0 : wd_c;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference model plus data memory.
module tb_load_store_unit;

  localparam int MSZ = 131072;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, rsp_valid, err, mem_en, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [16:0] mem_addr;
  logic [3:0]  mem_be;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(17)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .rsp_valid(rsp_valid), .rdata(rdata), .err(err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
  } exp_t;

  exp_t        exp_c;
  logic        chk_on = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [52:0] beat_q[$];
  logic [31:0] last_rd;
  int          rsp_cnt = 0;
  int          err_cnt = 0;

  logic [7:0] mem    [0:MSZ-1];
  logic [7:0] shadow [0:MSZ-1];

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endfunction

  // Data memory: read data appears the cycle after a read beat
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[{mem_addr[16:2], 2'(b)}] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= {mem[{mem_addr[16:2], 2'd3}], mem[{mem_addr[16:2], 2'd2}],
                      mem[{mem_addr[16:2], 2'd1}], mem[{mem_addr[16:2], 2'd0}]};
      end
    end
  end

  // Compare every output against the model each cycle, and log beats/responses
  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall",     64'(stall),     64'(exp_c.stall));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_c.rsp_valid));
      chk("rdata",     64'(rdata),     64'(exp_c.rdata));
      chk("err",       64'(err),       64'(exp_c.err));
      chk("mem_en",    64'(mem_en),    64'(exp_c.mem_en));
      chk("mem_we",    64'(mem_we),    64'(exp_c.mem_we));
      chk("mem_addr",  64'(mem_addr),  64'(exp_c.mem_addr));
      chk("mem_be",    64'(mem_be),    64'(exp_c.mem_be));
      chk("mem_wdata", 64'(mem_wdata), 64'(exp_c.mem_wdata));
      if (mem_en) beat_q.push_back({mem_addr, mem_be, mem_wdata});
      if (rsp_valid) begin
        last_rd = rdata;
        rsp_cnt++;
      end
      if (err) err_cnt++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    next_cycle();
    req_valid = 1'b0;
    exp_c     = '0;
  endtask

  // Model: a request touches bytes addr..addr+n-1 (mod memory size); each
  // distinct word touched is one beat. rst_at >= 0 pulses reset in that cycle.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int rst_at);
    int          n, nb, cycles;
    logic        ill;
    logic [16:0] ba[4];
    int          bi[4];
    logic [16:0] w[2];
    logic [3:0]  be[2];
    logic [31:0] wb[2];
    logic [31:0] val, res;
    exp_t        e;
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < 4; i++) begin
      ba[i] = a[16:0] + 17'(i);
      bi[i] = 0;
    end
    w[0] = {ba[0][16:2], 2'b00};
    w[1] = {ba[n-1][16:2], 2'b00};
    nb   = (w[1] != w[0]) ? 2 : 1;
    for (int k = 0; k < 2; k++) begin
      be[k] = '0;
      wb[k] = '0;
    end
    val = '0;
    for (int i = 0; i < n; i++) begin
      int lane;
      lane  = int'(ba[i][1:0]);
      bi[i] = (ba[i][16:2] == w[0][16:2]) ? 0 : 1;
      be[bi[i]][lane] = 1'b1;
      wb[bi[i]][8*lane +: 8] = wd[8*i +: 8];
      val[8*i +: 8] = shadow[ba[i]];
    end
    if (n == 1)      res = f3[2] ? {24'b0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
    else if (n == 2) res = f3[2] ? {16'b0, val[15:0]} : {{16{val[15]}}, val[15:0]};
    else             res = val;
    cycles = ill ? 1 : (we ? nb : nb + 1);
    beat_q.delete();
    for (int k = 0; k < cycles; k++) begin
      next_cycle();
      if (k == rst_at) begin
        rst       = 1'b1;
        req_valid = 1'b0;
        exp_c     = '0;
        next_cycle();
        rst   = 1'b0;
        exp_c = '0;
        @(negedge clk);
        #1;
        return;
      end
      req_valid = 1'b1;
      if (k == 0) begin
        req_we = we; funct3 = f3; addr = a; wdata = wd;
      end else begin
        req_we = ~we; funct3 = 3'b011; addr = ~a; wdata = ~wd;
      end
      e = '0;
      if (ill) begin
        e.err = 1'b1;
      end else if (k < nb) begin
        e.mem_en    = 1'b1;
        e.mem_we    = we;
        e.mem_addr  = w[k];
        e.mem_be    = be[k];
        e.mem_wdata = we ? wb[k] : 32'h0;
        e.stall     = we ? (k < nb - 1) : 1'b1;
        if (we)
          for (int i = 0; i < n; i++)
            if (bi[i] == k) shadow[ba[i]] = wd[8*i +: 8];
      end else begin
        e.rsp_valid = 1'b1;
        e.rdata     = res;
      end
      exp_c = e;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MSZ; i++) begin
      mem[i]    = 8'h00;
      shadow[i] = 8'h00;
    end
    mem_rdata = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; last_rd = '0;
    exp_c  = '0;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    do_req(1'b1, 3'b010, 32'h100, 32'h11223344, -1);
    chk("sw100_beat", 64'(beat_q[0]), 64'({17'h100, 4'b1111, 32'h11223344}));
    do_req(1'b0, 3'b010, 32'h100, 32'h0, -1);
    chk("lw100", 64'(last_rd), 64'h11223344);

    do_req(1'b1, 3'b000, 32'h103, 32'h000000A5, -1);
    chk("sb103_be", 64'(beat_q[0][35:32]), 64'b1000);
    chk("sb103_wd", 64'(beat_q[0][31:0]), 64'hA5000000);
    do_req(1'b0, 3'b000, 32'h103, 32'h0, -1);
    chk("lb103", 64'(last_rd), 64'hFFFFFFA5);
    do_req(1'b0, 3'b100, 32'h103, 32'h0, -1);
    chk("lbu103", 64'(last_rd), 64'h000000A5);

    do_req(1'b1, 3'b010, 32'h0FE, 32'h11223344, -1);
    chk("sw0fe_nbeats", 64'(beat_q.size()), 64'd2);
    chk("sw0fe_beat0", 64'(beat_q[0]), 64'({17'h0FC, 4'b1100, 32'h33440000}));
    chk("sw0fe_beat1", 64'(beat_q[1]), 64'({17'h100, 4'b0011, 32'h00001122}));
    do_req(1'b0, 3'b010, 32'h0FE, 32'h0, -1);
    chk("lw0fe", 64'(last_rd), 64'h11223344);

    do_req(1'b1, 3'b000, 32'h1FFFF, 32'h00000080, -1);
    do_req(1'b1, 3'b000, 32'h00000, 32'h00000001, -1);
    do_req(1'b0, 3'b001, 32'h1FFFF, 32'h0, -1);
    chk("lh_wrap_a0", 64'(beat_q[0][52:36]), 64'h1FFFC);
    chk("lh_wrap_a1", 64'(beat_q[1][52:36]), 64'h00000);
    chk("lh_wrap", 64'(last_rd), 64'h00000180);

    do_req(1'b0, 3'b001, 32'h102, 32'h0, -1);
    chk("lh102", 64'(last_rd), 64'hFFFFA522);
    do_req(1'b0, 3'b101, 32'h102, 32'h0, -1);
    chk("lhu102", 64'(last_rd), 64'h0000A522);
    do_req(1'b0, 3'b001, 32'h103, 32'h0, -1);
    chk("lh103", 64'(last_rd), 64'h000000A5);
    do_req(1'b1, 3'b001, 32'h107, 32'h0000BEEF, -1);
    do_req(1'b0, 3'b010, 32'h105, 32'h0, -1);
    do_req(1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, -1);
    do_req(1'b0, 3'b001, 32'h10E, 32'h0, -1);
    idle();

    err_cnt = 0;
    do_req(1'b0, 3'b011, 32'h100, 32'h0, -1);
    do_req(1'b1, 3'b110, 32'h100, 32'h12345678, -1);
    do_req(1'b0, 3'b111, 32'h0FE, 32'h0, -1);
    chk("err_pulses", 64'(err_cnt), 64'd3);
    idle();

    rsp_cnt = 0;
    do_req(1'b0, 3'b010, 32'h0FE, 32'h0, 1);
    chk("rst_ld_norsp", 64'(rsp_cnt), 64'd0);
    do_req(1'b1, 3'b010, 32'h2FE, 32'hAABBCCDD, 1);
    do_req(1'b0, 3'b010, 32'h2FC, 32'h0, -1);
    chk("rst_st_lo", 64'(last_rd), 64'hCCDD0000);
    do_req(1'b0, 3'b010, 32'h300, 32'h0, -1);
    chk("rst_st_hi", 64'(last_rd), 64'h00000000);

    idle();
    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
